dmem_wait_responder: RTL and testbench
======================================

Name: dmem_wait_responder

Overview:
- Memory-side responder for the core's data-memory request/valid interface.
- Accepts one read or byte-masked write at a time and inserts LATENCY wait cycles.
- Performs the access, then returns a single-cycle valid pulse with read data.
- Used in place of the zero-wait data memory, to exercise core stall handling under configurable memory latency.

Parameters:
- DataWidth, 32, word width; fixed at 32 (4 byte lanes).
- Address, 8, word-address width; array depth = 2**Address words.
- LATENCY, 2, wait cycles between request acceptance and the access; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- request  input  1  access request; held by the core until valid.
- we_re  input  1  1 = write, 0 = read; sampled with request.
- mask  input  4  byte-lane enables for writes (bit i = bits 8i+7:8i); ignored on reads.
- address  input  Address  word address.
- data_in  input  DataWidth  write data.
- valid  output  1  one-cycle completion pulse.
- data_out  output  DataWidth  read data; holds the last read value.
- busy  output  1  high when not IDLE.

Behaviour:
- Reset (async, active-high) forces:
  - FSM to IDLE; valid=0, busy=0, data_out=0, wait counter=0.
  - All latched request fields cleared.
  - Memory array contents not reset (undefined until written).
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If request=1 at a rising edge, latch we_re/mask/address/data_in, load counter with LATENCY-1, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - While the counter is nonzero, decrement it.
  - When the counter is 0, perform the access on that edge and go to RESP:
    - Write: each byte lane with mask[i]=1 is updated; other lanes are unchanged.
    - Read: data_out is loaded with the full word at the latched address.
- RESP: valid=1 for exactly this cycle; return to IDLE on the next edge.
- Latency: valid is high in the cycle following the (LATENCY+1)th rising edge, counting the edge that sampled request as edge 1. For LATENCY=2, valid is high after edge 3.
- request is ignored in WAIT and RESP. Input changes after acceptance have no effect (latched copy is used).
- A request still high in the cycle after RESP is treated as a new access. Back-to-back throughput is one access per LATENCY+2 cycles.
- Write with mask=4'b0000: no array change; valid still pulses; data_out unchanged.
- Writes never modify data_out.
- Read of a word written by the immediately preceding access returns the new data (the write completed before RESP).
- Reset asserted during WAIT: the pending write is discarded (array untouched) and no valid is issued. Reset asserted during RESP: valid drops immediately (async).
- Address wraps naturally; every Address-bit value is a legal word.
- valid and busy are registered outputs; no combinational path from inputs to outputs.

Decomposition:
- Shared package dmem_pkg:
  - State enum type (IDLE, WAIT, RESP).
  - Constants WE_WRITE=1'b1 and WE_READ=1'b0.
  - NUM_LANES=4.
- Sub-module dmem_byte_array: synchronous byte-lane-masked single-port array with inputs en, we, mask, addr, wdata and output rdata (registered). It has no reset.

Test Plan:
- Reset then idle: rst pulse, request=0 for 10 cycles -> valid=0, busy=0, data_out=0 throughout.
- Write then read, LATENCY=2:
  - Write addr 8'h10, data 32'hDEADBEEF, mask 4'hF -> valid after edge 3, busy high for the 3 cycles before.
  - Read addr 8'h10 -> data_out=32'hDEADBEEF with valid.
- Partial write:
  - Preload 32'h11223344, then write 32'hAABBCCDD with mask 4'b0101.
  - Read -> 32'h11BB33DD.
- Held request:
  - Keep request=1 with a read of addr 8'h01 for 12 cycles -> exactly 3 valid pulses, spaced 4 cycles apart.
  - Inputs changed mid-WAIT are ignored.
- Reset mid-write:
  - Preload 32'h0 at 8'h20, start write 32'hFFFFFFFF, assert rst during WAIT.
  - -> no valid; a subsequent read returns 32'h0.
- Zero-mask write and LATENCY=1 build: write mask 0 to a word holding 32'hCAFEF00D -> valid after edge 2; read back 32'hCAFEF00D.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the wait-state data-memory responder.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic WE_WRITE  = 1'b1;
   localparam logic WE_READ   = 1'b0;
   localparam int   NUM_LANES = 4;

endpackage

// File: rtl/dmem_byte_array.sv
// Single-port word array with per-byte write enables and a registered read port.
module dmem_byte_array
   import dmem_pkg::*;
#(
   parameter int DataWidth = 32,
   parameter int Address   = 8
) (
   input  logic                 clk,
   input  logic                 en,
   input  logic                 we,
   input  logic [NUM_LANES-1:0] mask,
   input  logic [Address-1:0]   addr,
   input  logic [DataWidth-1:0] wdata,
   output logic [DataWidth-1:0] rdata
);

   logic [DataWidth-1:0] mem [2**Address];

   // Masked lane write, or full-word read into rdata; rdata only moves on reads.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < NUM_LANES; i++) begin
               if (mask[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/dmem_wait_responder.sv
// Data-memory responder that inserts LATENCY wait cycles before each access
// and signals completion with a one-cycle valid pulse.
module dmem_wait_responder
   import dmem_pkg::*;
#(
   parameter int DataWidth = 32,
   parameter int Address   = 8,
   parameter int LATENCY   = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 request,
   input  logic                 we_re,
   input  logic [3:0]           mask,
   input  logic [Address-1:0]   address,
   input  logic [DataWidth-1:0] data_in,
   output logic                 valid,
   output logic [DataWidth-1:0] data_out,
   output logic                 busy
);

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_t               state;
   logic [3:0]           cnt;
   logic                 l_we;
   logic [3:0]           l_mask;
   logic [Address-1:0]   l_addr;
   logic [DataWidth-1:0] l_data;
   logic                 rd_seen;
   logic                 access;
   logic [DataWidth-1:0] rdata;

   // The access fires on the WAIT edge where the counter has run out.
   assign access = (state == WAIT) && (cnt == 4'd0);

   // The array has no reset, so data_out reads as zero until a read lands.
   assign data_out = rd_seen ? rdata : '0;

   // Request FSM: latch on accept, count down, pulse valid for one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         valid   <= 1'b0;
         busy    <= 1'b0;
         l_we    <= 1'b0;
         l_mask  <= '0;
         l_addr  <= '0;
         l_data  <= '0;
         rd_seen <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               valid <= 1'b0;
               if (request) begin
                  l_we   <= we_re;
                  l_mask <= mask;
                  l_addr <= address;
                  l_data <= data_in;
                  cnt    <= CNT_INIT;
                  busy   <= 1'b1;
                  state  <= WAIT;
               end
            end
            WAIT: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  valid <= 1'b1;
                  state <= RESP;
                  if (l_we == WE_READ) rd_seen <= 1'b1;
               end
            end
            RESP: begin
               valid <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               valid <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   dmem_byte_array #(
      .DataWidth (DataWidth),
      .Address   (Address)
   ) u_array (
      .clk   (clk),
      .en    (access),
      .we    (l_we == WE_WRITE),
      .mask  (l_mask),
      .addr  (l_addr),
      .wdata (l_data),
      .rdata (rdata)
   );

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Directed bench for dmem_wait_responder: LATENCY=2 instance (slot 0) and
// LATENCY=1 instance (slot 1) with separate request interfaces.
module tb_dmem_wait_responder;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [1:0]       req = '0;
   logic [1:0]       we  = '0;
   logic [1:0][3:0]  msk = '0;
   logic [1:0][7:0]  adr = '0;
   logic [1:0][31:0] din = '0;
   logic [1:0][31:0] dout;
   logic [1:0]       vld;
   logic [1:0]       bsy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dmem_wait_responder #(.DataWidth(32), .Address(8), .LATENCY(2)) dut0 (
      .clk(clk), .rst(rst), .request(req[0]), .we_re(we[0]), .mask(msk[0]),
      .address(adr[0]), .data_in(din[0]), .valid(vld[0]), .data_out(dout[0]),
      .busy(bsy[0]));

   dmem_wait_responder #(.DataWidth(32), .Address(8), .LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .request(req[1]), .we_re(we[1]), .mask(msk[1]),
      .address(adr[1]), .data_in(din[1]), .valid(vld[1]), .data_out(dout[1]),
      .busy(bsy[1]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge. Holds request until valid, returns the edge number
   // (accept edge = 1) on which valid appeared, busy cycles seen and data_out.
   task automatic access(input int s, input logic w, input logic [3:0] m,
                         input logic [7:0] a, input logic [31:0] d,
                         output int lat, output int bcnt, output logic [31:0] q);
      req[s] = 1'b1; we[s] = w; msk[s] = m; adr[s] = a; din[s] = d;
      lat = 0; bcnt = 0; q = '0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); @(negedge clk);
         if (bsy[s]) bcnt++;
         if (vld[s]) begin lat = i; break; end
      end
      q = dout[s];
      req[s] = 1'b0;
      if (lat == 0) begin
         checks++; errors++;
         $error("FAIL timeout: observed no valid expected valid within 40 cycles");
      end
      @(posedge clk); @(negedge clk);
      chk("valid_one_cycle", {31'd0, vld[s]}, 32'd0);
   endtask

   initial begin
      int lat, bc, pulses;
      int pos [3];
      logic [31:0] q;

      // Reset and idle
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_state", {vld[0], bsy[0], 30'd0} | dout[0], 32'd0);
      end

      // Full write then read, LATENCY=2
      access(0, 1'b1, 4'hF, 8'h10, 32'hDEADBEEF, lat, bc, q);
      chk("wr_latency", lat, 3);
      chk("wr_busy_cycles", bc, 3);
      chk("wr_no_dout_change", q, 32'h0);
      access(0, 1'b0, 4'h0, 8'h10, 32'h0, lat, bc, q);
      chk("rd_latency", lat, 3);
      chk("rd_data", q, 32'hDEADBEEF);

      // Partial write
      access(0, 1'b1, 4'hF, 8'h40, 32'h11223344, lat, bc, q);
      access(0, 1'b1, 4'b0101, 8'h40, 32'hAABBCCDD, lat, bc, q);
      chk("partial_wr_keeps_dout", q, 32'hDEADBEEF);
      access(0, 1'b0, 4'h0, 8'h40, 32'h0, lat, bc, q);
      chk("partial_rd", q, 32'h11BB33DD);

      // Held request with inputs disturbed mid-WAIT
      access(0, 1'b1, 4'hF, 8'h01, 32'h01010101, lat, bc, q);
      access(0, 1'b1, 4'hF, 8'h02, 32'h02020202, lat, bc, q);
      req[0] = 1'b1; we[0] = 1'b0; msk[0] = 4'h0; adr[0] = 8'h01; din[0] = 32'h0;
      pulses = 0;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk); @(negedge clk);
         if (i == 1) begin we[0] = 1'b1; msk[0] = 4'hF; adr[0] = 8'h02; din[0] = 32'hBAD0BAD0; end
         if (i == 3) begin we[0] = 1'b0; msk[0] = 4'h0; adr[0] = 8'h01; din[0] = 32'h0; end
         if (vld[0]) begin
            if (pulses < 3) pos[pulses] = i;
            pulses++;
            chk("held_rd_data", dout[0], 32'h01010101);
         end
      end
      req[0] = 1'b0;
      chk("held_pulse_count", pulses, 3);
      if (pulses >= 3) begin
         chk("held_pos0", pos[0], 3);
         chk("held_pos1", pos[1], 7);
         chk("held_pos2", pos[2], 11);
      end
      @(negedge clk);
      access(0, 1'b0, 4'h0, 8'h02, 32'h0, lat, bc, q);
      chk("midwait_ignored", q, 32'h02020202);

      // Reset during a pending write
      access(0, 1'b1, 4'hF, 8'h20, 32'h0, lat, bc, q);
      req[0] = 1'b1; we[0] = 1'b1; msk[0] = 4'hF; adr[0] = 8'h20; din[0] = 32'hFFFFFFFF;
      @(posedge clk); @(negedge clk);
      chk("pre_rst_busy", {31'd0, bsy[0]}, 32'd1);
      rst = 1'b1; req[0] = 1'b0;
      #1;
      chk("rst_outputs", {vld[0], bsy[0], 30'd0} | dout[0], 32'd0);
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (vld[0]) pulses++;
      end
      chk("rst_no_valid", pulses, 0);
      access(0, 1'b0, 4'h0, 8'h20, 32'h0, lat, bc, q);
      chk("rst_write_discarded", q, 32'h0);

      // LATENCY=1 instance: zero-mask write
      access(1, 1'b1, 4'hF, 8'h30, 32'hCAFEF00D, lat, bc, q);
      access(1, 1'b0, 4'h0, 8'h30, 32'h0, lat, bc, q);
      chk("l1_rd_latency", lat, 2);
      chk("l1_rd_data", q, 32'hCAFEF00D);
      access(1, 1'b1, 4'h0, 8'h30, 32'h12345678, lat, bc, q);
      chk("l1_zmask_latency", lat, 2);
      chk("l1_zmask_busy_cycles", bc, 2);
      chk("l1_zmask_dout", q, 32'hCAFEF00D);
      access(1, 1'b0, 4'h0, 8'h30, 32'h0, lat, bc, q);
      chk("l1_zmask_rd", q, 32'hCAFEF00D);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
